// File: rtl/i2c_pkg.sv
// Shared widths, depth defaults and FSM state encoding for the I2C host command stage.
package i2c_pkg;

    localparam int DEF_FIFO_DEPTH = 16;
    localparam int DEF_DATA_W     = 8;
    localparam int DEF_ADDR_W     = 7;
    localparam int DEF_CNT_W      = 4;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_CHECK = 2'd1;
    localparam state_t ST_REQ   = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    // Pointer width carries one extra wrap bit so full and empty can be told apart.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/i2c_sync_fifo.sv
// Single-clock FIFO with first-word fall-through read data and wrap-bit pointers.
// A pop frees space in the same cycle, so push-and-pop while full is accepted.
module i2c_sync_fifo
    import i2c_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH,
    parameter int WIDTH = DEF_DATA_W,
    localparam int PW   = ptr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [PW-1:0]    count
);

    localparam int AW = PW - 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_wr;
    logic             do_rd;

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_rd    = rd_en && !empty;
        do_wr    = wr_en && (!full || do_rd);
        wr_ptr_d = do_wr ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = do_rd ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count    = wr_ptr_q - rd_ptr_q;
        rd_data  = mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset; the read side is qualified by empty.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/i2c_host_ctrl.sv
// Host command and buffer stage in front of top_i2c: one command at a time,
// TX/RX byte FIFOs, transaction request handshake and completion reporting.
//
// state    | meaning
// ST_IDLE  | cmd_ready high, waiting for a host command
// ST_CHECK | waiting for enough TX bytes (write) or RX space (read)
// ST_REQ   | i_ready high until top_i2c pulses i2c_done
// ST_DONE  | one-cycle xfer_done pulse
module i2c_host_ctrl
    import i2c_pkg::*;
#(
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic              cmd_rw,
    input  logic [CNT_W-1:0]  cmd_cnt,
    input  logic              tx_wr_en,
    input  logic [DATA_W-1:0] tx_wr_data,
    output logic              tx_full,
    input  logic              rx_rd_en,
    output logic [DATA_W-1:0] rx_rd_data,
    output logic              rx_empty,
    output logic              xfer_done,
    output logic              xfer_err,
    output logic              i_ready,
    output logic [ADDR_W-1:0] addr,
    output logic              rw,
    output logic [CNT_W-1:0]  data_cnt,
    output logic [DATA_W-1:0] data_in,
    input  logic              i_txff_rd,
    input  logic [DATA_W-1:0] data_out,
    input  logic              i_rxff_wr,
    input  logic              i2c_done
);

    localparam int PW = ptr_w(FIFO_DEPTH);

    state_t            state_q, state_d;
    logic              i_ready_q, i_ready_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rw_q, rw_d;
    logic [CNT_W-1:0]  data_cnt_q, data_cnt_d;

    logic [DATA_W-1:0] tx_head, rx_head;
    logic              tx_empty, rx_full;
    logic [PW-1:0]     tx_count, rx_count, rx_free, need;
    logic              accept, tx_underflow, rx_drop, ready_to_go;

    i2c_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (tx_wr_en),
        .wr_data (tx_wr_data),
        .rd_en   (i_txff_rd),
        .rd_data (tx_head),
        .full    (tx_full),
        .empty   (tx_empty),
        .count   (tx_count)
    );

    i2c_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (i_rxff_wr),
        .wr_data (data_out),
        .rd_en   (rx_rd_en),
        .rd_data (rx_head),
        .full    (rx_full),
        .empty   (rx_empty),
        .count   (rx_count)
    );

    always_comb begin
        accept       = cmd_valid && (state_q == ST_IDLE);
        tx_underflow = i_txff_rd && tx_empty;
        // A same-cycle host pop makes room, so the byte is not lost.
        rx_drop      = i_rxff_wr && rx_full && !rx_rd_en;
        need         = PW'(data_cnt_q);
        rx_free      = PW'(FIFO_DEPTH) - rx_count;
        ready_to_go  = rw_q ? (rx_free >= need) : (tx_count >= need);
    end

    always_comb begin
        state_d    = state_q;
        i_ready_d  = i_ready_q;
        addr_d     = addr_q;
        rw_d       = rw_q;
        data_cnt_d = data_cnt_q;
        err_d      = err_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    addr_d     = cmd_addr;
                    rw_d       = cmd_rw;
                    data_cnt_d = cmd_cnt;
                    err_d      = (cmd_cnt == '0);
                    state_d    = (cmd_cnt == '0) ? ST_DONE : ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (ready_to_go) begin
                    state_d   = ST_REQ;
                    i_ready_d = 1'b1;
                end
            end
            ST_REQ: begin
                if (i2c_done) begin
                    state_d   = ST_DONE;
                    i_ready_d = 1'b0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                i_ready_d = 1'b0;
            end
        endcase

        if (tx_underflow || rx_drop) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            i_ready_q  <= 1'b0;
            err_q      <= 1'b0;
            addr_q     <= '0;
            rw_q       <= 1'b0;
            data_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            i_ready_q  <= i_ready_d;
            err_q      <= err_d;
            addr_q     <= addr_d;
            rw_q       <= rw_d;
            data_cnt_q <= data_cnt_d;
        end
    end

    always_comb begin
        cmd_ready  = (state_q == ST_IDLE);
        xfer_done  = (state_q == ST_DONE);
        xfer_err   = err_q;
        i_ready    = i_ready_q;
        addr       = addr_q;
        rw         = rw_q;
        data_cnt   = data_cnt_q;
        data_in    = tx_empty ? '0 : tx_head;
        rx_rd_data = rx_empty ? '0 : rx_head;
    end

endmodule
